// File: rtl/tpram_be.sv
// Two-port byte-enable RAM (one write port, one read port, single clock) with
// a 1..3 stage read pipeline. Define TPRAM_BYPASS_EN for write-first same-address reads.
module tpram_be #(
  parameter  int WIDTH  = 32,
  parameter  int SIZE   = 2048,
  parameter  int RD_LAT = 1,
  localparam int NBE    = WIDTH / 8,
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NBE-1:0]   wbe,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             ready,
  output logic             rerr,
  output logic             werr
);

  generate
    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
      $error("tpram_be: RD_LAT must be in 1..3");
    end
    if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
      $error("tpram_be: WIDTH must be a positive multiple of 8");
    end
  endgenerate

  localparam logic [AW:0] SIZE_W = (AW+1)'(SIZE);
  localparam int          LAST   = RD_LAT - 1;

  logic [WIDTH-1:0] mem_q [SIZE];

  logic             w_in_range;
  logic             r_in_range;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] mem_wdata_d;
  logic [WIDTH-1:0] rd_word;

  // Read handshake: each request sampled with ren=1 produces exactly one
  // ready pulse RD_LAT flops later; rdata/rerr are meaningful only while
  // ready=1, and rdata holds the last returned word otherwise.
  logic             vld_d [RD_LAT];
  logic             vld_q [RD_LAT];
  logic [WIDTH-1:0] dat_d [RD_LAT];
  logic [WIDTH-1:0] dat_q [RD_LAT];
  logic             err_d [RD_LAT];
  logic             err_q [RD_LAT];
  logic             werr_d;
  logic             werr_q;

  assign w_in_range = ({1'b0, waddr} < SIZE_W);
  assign r_in_range = ({1'b0, raddr} < SIZE_W);

  always_comb begin
    wr_old      = w_in_range ? mem_q[waddr] : '0;
    mem_wdata_d = wr_old;
    for (int b = 0; b < NBE; b++) begin
      if (wbe[b]) mem_wdata_d[8*b +: 8] = wdata[8*b +: 8];
    end
    rd_word = r_in_range ? mem_q[raddr] : '0;
`ifdef TPRAM_BYPASS_EN
    if (wen && w_in_range && (waddr == raddr)) rd_word = mem_wdata_d;
`else
    // Read-first: the read sees the array before this edge's write commits.
`endif
  end

  always_comb begin
    vld_d[0] = ren;
    dat_d[0] = ren ? rd_word : dat_q[0];
    err_d[0] = ren & ~r_in_range;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      // Stages only load on a valid slot so the output word is sticky.
      dat_d[k] = vld_q[k-1] ? dat_q[k-1] : dat_q[k];
      err_d[k] = err_q[k-1];
    end
    werr_d = wen & ~w_in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
    end else if (wen && w_in_range) begin
      mem_q[waddr] <= mem_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_q[k] <= 1'b0;
        dat_q[k] <= '0;
        err_q[k] <= 1'b0;
      end
      werr_q <= 1'b0;
    end else begin
      for (int k = 0; k < RD_LAT; k++) begin
        vld_q[k] <= vld_d[k];
        dat_q[k] <= dat_d[k];
        err_q[k] <= err_d[k];
      end
      werr_q <= werr_d;
    end
  end

  assign ready = vld_q[LAST];
  assign rdata = dat_q[LAST];
  assign rerr  = err_q[LAST];
  assign werr  = werr_q;

endmodule

// File: tb/tb_tpram_be.sv
// Directed table-driven bench for tpram_be (SIZE=1000, RD_LAT=3); expectations
// follow TPRAM_BYPASS_EN when it is defined.
module tb_tpram_be;

  localparam int W      = 32;
  localparam int SIZE   = 1000;
  localparam int RD_LAT = 3;
  localparam int AW     = 10;
  localparam int NBE    = W / 8;
`ifdef TPRAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic           wen;
    logic [AW-1:0]  waddr;
    logic [W-1:0]   wdata;
    logic [NBE-1:0] wbe;
    logic           ren;
    logic [AW-1:0]  raddr;
    logic [W-1:0]   exp_rdata;
    logic           exp_rerr;
    logic           exp_werr;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wen = 1'b0;
  logic [AW-1:0]  waddr = '0;
  logic [W-1:0]   wdata = '0;
  logic [NBE-1:0] wbe = '0;
  logic           ren = 1'b0;
  logic [AW-1:0]  raddr = '0;
  logic [W-1:0]   rdata;
  logic           ready;
  logic           rerr;
  logic           werr;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           due_q[$];
  int           werr_due_q[$];
  logic [W-1:0] last_exp = '0;
  vec_t         vecs[$];

  tpram_be #(.WIDTH(W), .SIZE(SIZE), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr),
    .rdata(rdata), .ready(ready), .rerr(rerr), .werr(werr)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(logic w, int wa, logic [W-1:0] wd, logic [NBE-1:0] be,
                              logic r, int ra, logic [W-1:0] ed, logic ee, logic ew);
    vec_t v;
    v.wen = w; v.waddr = AW'(wa); v.wdata = wd; v.wbe = be;
    v.ren = r; v.raddr = AW'(ra);
    v.exp_rdata = ed; v.exp_rerr = ee; v.exp_werr = ew;
    return v;
  endfunction

  // Driver: inputs change 1ns after an edge and are sampled on the next edge.
  task automatic drive(input vec_t v);
    @(posedge clk); #1;
    wen = v.wen; waddr = v.waddr; wdata = v.wdata; wbe = v.wbe;
    ren = v.ren; raddr = v.raddr;
    if (v.ren) begin
      due_q.push_back(cyc + RD_LAT);
      exp_q.push_back(v.exp_rdata);
      err_q.push_back(v.exp_rerr);
    end
    if (v.exp_werr) werr_due_q.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, '0, '0, 0, 0, '0, 0, 0));
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0;
    exp_q.delete(); err_q.delete(); due_q.delete(); werr_due_q.delete();
    last_exp = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Scoreboard: every cycle, ready/rerr/werr/rdata against the expected queues.
  always @(negedge clk) begin
    logic exp_rdy;
    logic exp_werr;
    exp_rdy  = (due_q.size() > 0) && (due_q[0] == cyc);
    exp_werr = (werr_due_q.size() > 0) && (werr_due_q[0] == cyc);
    check("ready", W'(ready), W'(exp_rdy));
    if (exp_rdy) begin
      void'(due_q.pop_front());
      last_exp = exp_q.pop_front();
      check("rdata", rdata, last_exp);
      check("rerr", W'(rerr), W'(err_q.pop_front()));
    end else begin
      check("rdata_hold", rdata, last_exp);
      check("rerr_idle", W'(rerr), '0);
    end
    check("werr", W'(werr), W'(exp_werr));
    if (exp_werr) void'(werr_due_q.pop_front());
  end

  initial begin
    // rd 5 after reset, byte-enable merge, back-to-back reads
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 5,    32'h0000_0000, 0, 0));
    vecs.push_back(mk(1, 10,   32'hDEADBEEF, 4'hF, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(1, 10,   32'h11223344, 4'h5, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 10,   32'hDE22BE44,  0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, i, 32'hA0 + 32'(i), 4'hF, 0, 0, '0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 0, '0, 4'h0, 1, i, 32'hA0 + 32'(i), 0, 0));
    // same-edge same-address: full and partial byte enables, and wbe=0
    vecs.push_back(mk(1, 7,    32'hCAFEF00D, 4'hF, 1, 7,    BYP ? 32'hCAFEF00D : 32'h0, 0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 7,    32'hCAFEF00D,  0, 0));
    vecs.push_back(mk(1, 10,   32'h55000000, 4'h8, 1, 10,   BYP ? 32'h5522BE44 : 32'hDE22BE44, 0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 10,   32'h5522BE44,  0, 0));
    vecs.push_back(mk(1, 10,   32'hFFFFFFFF, 4'h0, 1, 10,   32'h5522BE44,  0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 10,   32'h5522BE44,  0, 0));
    vecs.push_back(mk(1, 30,   32'h12345678, 4'hF, 1, 3,    32'h000000A3,  0, 0));
    // out-of-range accesses and the boundary entries around SIZE
    vecs.push_back(mk(1, 1000, 32'h99999999, 4'hF, 0, 0,    '0,            0, 1));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 1023, 32'h0,         1, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 1000, 32'h0,         1, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 999,  32'h0,         0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 488,  32'h0,         0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 30,   32'h12345678,  0, 0));
    vecs.push_back(mk(1, 999,  32'hBBBBBBBB, 4'hF, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 999,  32'hBBBBBBBB,  0, 0));
    // read captured before a later write to the same entry
    vecs.push_back(mk(1, 20,   32'h00000001, 4'hF, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 20,   32'h00000001,  0, 0));
    vecs.push_back(mk(1, 20,   32'h00000002, 4'hF, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 0, 0,    '0,            0, 0));
    vecs.push_back(mk(0, 0,    '0,           4'h0, 1, 20,   32'h00000002,  0, 0));

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    idle(RD_LAT + 2);

    // In-flight read dropped by reset; memory and rdata cleared.
    drive(mk(0, 0, '0, 4'h0, 1, 30, 32'h12345678, 0, 0));
    reset_pulse();
    idle(RD_LAT + 2);
    drive(mk(0, 0, '0, 4'h0, 1, 30,  32'h0, 0, 0));
    drive(mk(0, 0, '0, 4'h0, 1, 999, 32'h0, 0, 0));
    drive(mk(0, 0, '0, 4'h0, 1, 10,  32'h0, 0, 0));
    idle(RD_LAT + 2);

    check("pending_reads", W'(due_q.size()), '0);
    check("pending_werr", W'(werr_due_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tpram_be.md
Name: tpram_be

Overview:
- Parametrised two-port RAM: one write port, one read port, both on one clock.
- Successor to the team's delay-1 single-port RAM. Adds per-byte write enables, configurable read latency (1-3), out-of-range detection for non-power-of-two depths, and optional write-first bypass.
- Serves as the generic buffer macro behind scan-chain capture/replay storage.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8; NBE = WIDTH/8
SIZE, 2048, number of entries; any value >= 2; AW = $clog2(SIZE)
RD_LAT, 1, read latency in cycles; legal 1..3; elaboration error otherwise

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
wen  input  1  write request
waddr  input  AW  write address
wdata  input  WIDTH  write data
wbe  input  NBE  byte enables; bit i covers wdata[8i+7:8i]
ren  input  1  read request
raddr  input  AW  read address
rdata  output  WIDTH  read data, valid while ready=1
ready  output  1  one-cycle pulse per accepted read
rerr  output  1  read-address error, aligned with ready
werr  output  1  registered pulse, 1 cycle after an out-of-range write

Behaviour:
- Reset (async assert, sync release): all entries = 0; rdata = 0, ready = 0, rerr = 0, werr = 0; read pipeline flushed.
- Reset mid-operation: in-flight reads are dropped, no ready pulse is produced for them, and memory is cleared.
- Write: on the clk edge with wen=1 and waddr<SIZE, entry[waddr] byte i <= wdata byte i for each wbe[i]=1; other bytes are unchanged.
  - wen=1 with wbe=0 is a legal no-op.
- Out-of-range write (waddr>=SIZE, only possible if SIZE is not a power of two): memory unchanged; werr=1 next cycle.
- Read: ren is sampled at edge T. Data are captured from the array as it stands at T, before the write at T commits, unless bypass applies.
  - ready=1, with rdata and rerr valid, exactly during cycle T+RD_LAT (RD_LAT-stage pipeline).
- ren=0: that pipeline slot carries valid=0; rdata keeps its previous value when ready=0.
- Back-to-back reads: one read is accepted per cycle, with no bubbles; throughput is 1 read per cycle at every RD_LAT.
- Out-of-range read: rdata = 0, rerr = 1 alongside ready = 1.
- Writes issued after a read's capture edge never alter that read's result.
- Simultaneous wen/ren to different addresses are fully independent.
- Same-address wen/ren on one edge: result depends on the optional feature below.
- No internal FSM beyond the valid/data shift pipeline. ready, rerr and werr are all registered outputs.

Optional Feature:
- Macro: TPRAM_BYPASS_EN
- Defined (write-first): a same-edge, same-address in-range read returns the merged word: wdata bytes where wbe=1, old entry bytes elsewhere.
- Not defined (read-first): that read returns the old entry contents.
- Array update is identical in both modes.

Test Plan:
- Reset, then read addr 5 -> ready pulses at T+RD_LAT, rdata=0x00000000, rerr=0. Assert rst_n low between issue and return -> no ready pulse.
- Write addr 10 = 0xDEADBEEF with wbe=4'b1111, then write addr 10 = 0x11223344 with wbe=4'b0101, then read addr 10 -> rdata=0xDE22BE44.
- RD_LAT=3: ren held 1 for 4 cycles at addrs 0-3 preloaded 0xA0-0xA3 -> ready high 4 consecutive cycles starting T+3, rdata 0xA0,0xA1,0xA2,0xA3 in order.
- Addr 7 holds 0x00000000; same edge: wen addr 7 = 0xCAFEF00D with wbe=4'b1111, plus ren addr 7 -> 0xCAFEF00D with TPRAM_BYPASS_EN defined, 0x00000000 without; a later read returns 0xCAFEF00D in both.
- SIZE=1000: write addr 1000 -> werr=1 one cycle later, no entry changed. Read addr 1023 -> rdata=0, rerr=1 with ready.
- Read addr 20 (holds 0x1), then write addr 20 = 0x2 on the next edge, RD_LAT=2 -> returned rdata=0x1.
